// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted conditional branches awaiting resolution.
// Drives registered predictor-training updates and one-cycle mispredict redirects.
module branch_resolve_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc,
    input  logic [15:0]   alloc_pc,
    input  logic          alloc_pred,
    input  logic [15:0]   alloc_alt_pc,
    output logic          full,
    input  logic          resolve,
    input  logic          resolve_taken,
    output logic          upd_valid,
    output logic [15:0]   upd_pc,
    output logic          upd_taken,
    output logic          mispredict,
    output logic [15:0]   redirect_pc,
    output logic [AW:0]   count,
    output logic          underflow
);

    logic [15:0] pc_mem   [DEPTH];
    logic        pred_mem [DEPTH];
    logic [15:0] alt_mem  [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic          do_resolve;
    logic          do_alloc;
    logic          squash;
    logic          empty;
    logic [15:0]   head_pc;
    logic          head_pred;
    logic [15:0]   head_alt;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign empty = (count_q == '0);

    assign head_pc   = pc_mem[rd_ptr_q];
    assign head_pred = pred_mem[rd_ptr_q];
    assign head_alt  = alt_mem[rd_ptr_q];

    always_comb begin
        do_resolve = resolve && !empty;
        squash     = do_resolve && (resolve_taken != head_pred);
        // An alloc racing a squash is on the wrong path and must not land.
        do_alloc   = alloc && !full && !squash;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_resolve) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (squash) begin
            wr_ptr_d = rd_ptr_q + AW'(1);
            count_d  = '0;
        end else begin
            if (do_alloc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            case ({do_alloc, do_resolve})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            upd_valid   <= 1'b0;
            upd_pc      <= '0;
            upd_taken   <= 1'b0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
            underflow   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            upd_valid  <= do_resolve;
            mispredict <= squash;
            if (do_resolve) begin
                upd_pc    <= head_pc;
                upd_taken <= resolve_taken;
            end
            if (squash) begin
                redirect_pc <= head_alt;
            end
            if (resolve && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Entry storage is deliberately left unreset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            pc_mem[wr_ptr_q]   <= alloc_pc;
            pred_mem[wr_ptr_q] <= alloc_pred;
            alt_mem[wr_ptr_q]  <= alloc_alt_pc;
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue: stimulus pushes expected updates,
// a negedge monitor pops and compares whenever upd_valid or mispredict is seen.
module tb_branch_resolve_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alloc = 1'b0;
    logic [15:0]   alloc_pc = '0;
    logic          alloc_pred = 1'b0;
    logic [15:0]   alloc_alt_pc = '0;
    logic          full;
    logic          resolve = 1'b0;
    logic          resolve_taken = 1'b0;
    logic          upd_valid;
    logic [15:0]   upd_pc;
    logic          upd_taken;
    logic          mispredict;
    logic [15:0]   redirect_pc;
    logic [AW:0]   count;
    logic          underflow;

    branch_resolve_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .alloc(alloc), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
        .alloc_alt_pc(alloc_alt_pc), .full(full),
        .resolve(resolve), .resolve_taken(resolve_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .count(count), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        pred;
        logic [15:0] alt;
    } ent_t;

    typedef struct {
        logic [15:0] pc;
        logic        taken;
        logic        mis;
        logic [15:0] red;
    } exp_t;

    ent_t mq[$];
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every DUT output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (upd_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_upd_valid", 32'(upd_pc), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("upd_pc", 32'(upd_pc), 32'(e.pc));
                    chk("upd_taken", 32'(upd_taken), 32'(e.taken));
                    chk("mispredict", 32'(mispredict), 32'(e.mis));
                    if (e.mis) chk("redirect_pc", 32'(redirect_pc), 32'(e.red));
                end
            end else if (mispredict) begin
                chk("mispredict_without_upd", 32'(mispredict), 32'd0);
            end
        end
    end

    // One clock of stimulus; the bench's reference queue advances at the same edge.
    task automatic cycle(input logic a, input logic [15:0] pc, input logic pred,
                         input logic [15:0] alt, input logic r, input logic taken);
        logic acc, sq;
        ent_t h;
        alloc = a; alloc_pc = pc; alloc_pred = pred; alloc_alt_pc = alt;
        resolve = r; resolve_taken = taken;
        @(posedge clk);
        acc = a && (mq.size() < DEPTH);
        sq  = 1'b0;
        if (r && mq.size() > 0) begin
            h  = mq.pop_front();
            sq = (taken != h.pred);
            sb.push_back('{h.pc, taken, sq, h.alt});
            if (sq) mq.delete();
        end
        if (acc && !sq) mq.push_back('{pc, pred, alt});
        #1;
        alloc = 1'b0; resolve = 1'b0; resolve_taken = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #12 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);

        // Correct predictions, back-to-back resolves
        cycle(1, 16'h3000, 1, 16'h3100, 0, 0);
        cycle(1, 16'h3004, 0, 16'h3104, 0, 0);
        cycle(1, 16'h3008, 1, 16'h3108, 0, 0);
        chk("a_count3", 32'(count), 32'd3);
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 1);
        chk("a_count0", 32'(count), 32'd0);
        idle(2);

        // Mispredict squash with a concurrent wrong-path alloc
        cycle(1, 16'h3010, 0, 16'h3050, 0, 0);
        cycle(1, 16'h3014, 1, 16'h3060, 0, 0);
        cycle(1, 16'h3018, 1, 16'h3070, 0, 0);
        cycle(1, 16'h301C, 1, 16'h3080, 1, 1);
        chk("b_count_after_squash", 32'(count), 32'd0);
        chk("b_mispredict_pulse", 32'(mispredict), 32'd1);
        // Redirected alloc in the same cycle as the mispredict pulse
        cycle(1, 16'h3020, 1, 16'h3090, 0, 0);
        chk("b_count_redirected", 32'(count), 32'd1);
        cycle(0, 0, 0, 0, 1, 1);
        chk("b_count_drained", 32'(count), 32'd0);
        idle(2);

        // Fill to full, reject ninth, simultaneous at full, then wrap
        for (int i = 0; i < 8; i++) cycle(1, 16'h4000 + 16'(i * 4), i[0], 16'h4400, 0, 0);
        chk("c_full", 32'(full), 32'd1);
        chk("c_count8", 32'(count), 32'd8);
        cycle(1, 16'h40F0, 0, 16'h4400, 0, 0);
        chk("c_ninth_dropped", 32'(count), 32'd8);
        cycle(1, 16'h4100, 0, 16'h4400, 1, 0);
        chk("c_simul_full_count", 32'(count), 32'd7);
        chk("c_simul_full_nfull", 32'(full), 32'd0);
        for (int k = 0; k < 20; k++) begin
            cycle(1, 16'h4200 + 16'(k * 4), k[0], 16'h4400, 1, mq[0].pred);
        end
        chk("c_wrap_count", 32'(count), 32'd7);
        for (int k = 0; k < 7; k++) cycle(0, 0, 0, 0, 1, mq[0].pred);
        chk("c_drain_count", 32'(count), 32'd0);
        idle(2);

        // Underflow is sticky across normal traffic
        cycle(0, 0, 0, 0, 1, 1);
        chk("d_underflow_set", 32'(underflow), 32'd1);
        cycle(1, 16'h5000, 1, 16'h5100, 0, 0);
        cycle(0, 0, 0, 0, 1, 1);
        idle(1);
        chk("d_underflow_sticky", 32'(underflow), 32'd1);
        chk("d_count0", 32'(count), 32'd0);

        // Asynchronous reset with entries queued and an update pending
        for (int i = 0; i < 4; i++) cycle(1, 16'h6000 + 16'(i * 4), 1, 16'h6100, 0, 0);
        cycle(0, 0, 0, 0, 1, 1);
        chk("e_pending_upd", 32'(upd_valid), 32'd1);
        #2 rst = 1'b1;
        mq.delete();
        sb.delete();
        #1;
        chk("e_rst_count", 32'(count), 32'd0);
        chk("e_rst_full", 32'(full), 32'd0);
        chk("e_rst_upd_valid", 32'(upd_valid), 32'd0);
        chk("e_rst_mispredict", 32'(mispredict), 32'd0);
        chk("e_rst_underflow", 32'(underflow), 32'd0);
        @(negedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        cycle(1, 16'h7000, 0, 16'h7100, 0, 0);
        chk("e_post_rst_count", 32'(count), 32'd1);
        cycle(0, 0, 0, 0, 1, 0);
        idle(3);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
